// File: rtl/pcie_wrap0_byte_stream_arbiter.sv
// Round-robin, burst-limited arbiter that merges NUM_CH valid-only byte sources into one
// Avalon-ST byte stream. Optional macro PCIE_WRAP0_BYTE_ARB_CH0_PRIO_EN gives channel 0 strict priority.
module pcie_wrap0_byte_stream_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BURST  = 2,
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_CH-1:0]     in_valid,
    input  logic [NUM_CH*8-1:0]   in_data,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    output logic [CH_W-1:0]       out_channel,
    input  logic                  out_ready,
    output logic [NUM_CH-1:0]     overflow,
    input  logic [NUM_CH-1:0]     overflow_clr,
    output logic                  busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    logic [7:0]        mem    [NUM_CH][FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr [NUM_CH];
    logic [PW-1:0]     rd_ptr [NUM_CH];
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] push;

    state_t            state;
    logic [CH_W-1:0]   gnt;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   rr_next;
    logic [CH_W-1:0]   sel;
    logic [CH_W:0]     idx_w;
    logic              found;
    logic [7:0]        burst_cnt;
    logic              prio_hit;
    logic              gnt_is_prio;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                       (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
        end
    end

    assign out_valid   = (state == GRANT) && !empty[gnt];
    assign out_data    = out_valid ? mem[gnt][rd_ptr[gnt][AW-1:0]] : 8'h00;
    assign out_channel = gnt;
    assign busy        = (|(~empty)) || (state == GRANT);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            pop[i]  = out_valid && out_ready && (gnt == CH_W'(i));
            push[i] = in_valid[i] && (!full[i] || pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            overflow <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                // A fresh drop outranks a clear request in the same cycle.
                if (in_valid[i] && full[i] && !pop[i]) begin
                    overflow[i] <= 1'b1;
                end else if (overflow_clr[i]) begin
                    overflow[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset_n && push[i]) begin
                mem[i][wr_ptr[i][AW-1:0]] <= in_data[8*i +: 8];
            end
        end
    end

    // Scan from rr_ptr upward with wrap; iterating backwards lets the nearest channel win.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx_w = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx_w = {1'b0, rr_ptr} + (CH_W+1)'(k);
            if (idx_w >= (CH_W+1)'(NUM_CH)) begin
                idx_w = idx_w - (CH_W+1)'(NUM_CH);
            end
            if (!empty[idx_w[CH_W-1:0]]) begin
                found = 1'b1;
                sel   = idx_w[CH_W-1:0];
            end
        end
    end

    assign rr_next = (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + CH_W'(1);

`ifdef PCIE_WRAP0_BYTE_ARB_CH0_PRIO_EN
    assign prio_hit    = !empty[0];
    assign gnt_is_prio = (gnt == '0);
`else
    assign prio_hit    = 1'b0;
    assign gnt_is_prio = 1'b0;
`endif

    // A priority grant neither rotates rr_ptr nor is cut short by the burst limit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            gnt       <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    if (prio_hit) begin
                        state <= GRANT;
                        gnt   <= '0;
                    end else if (found) begin
                        state <= GRANT;
                        gnt   <= sel;
                    end
                end
                GRANT: begin
                    if (!out_valid) begin
                        state <= IDLE;
                        if (!gnt_is_prio) begin
                            rr_ptr <= rr_next;
                        end
                    end else if (out_ready) begin
                        burst_cnt <= burst_cnt + 8'd1;
                        if (!gnt_is_prio && (burst_cnt == 8'(MAX_BURST - 1))) begin
                            state  <= IDLE;
                            rr_ptr <= rr_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_wrap0_byte_stream_arbiter.sv
// Directed scoreboard bench for pcie_wrap0_byte_stream_arbiter (NUM_CH=4, FIFO_DEPTH=4, MAX_BURST=2).
// The channel-0 priority scenario runs only when PCIE_WRAP0_BYTE_ARB_CH0_PRIO_EN is defined.
module tb_pcie_wrap0_byte_stream_arbiter;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic              clk;
    logic              reset_n;
    logic [NUM_CH-1:0] in_valid;
    logic [31:0]       in_data;
    logic              out_valid;
    logic [7:0]        out_data;
    logic [CH_W-1:0]   out_channel;
    logic              out_ready;
    logic [NUM_CH-1:0] overflow;
    logic [NUM_CH-1:0] overflow_clr;
    logic              busy;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    pcie_wrap0_byte_stream_arbiter #(
        .NUM_CH(4), .FIFO_DEPTH(4), .MAX_BURST(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_channel(out_channel),
        .out_ready(out_ready), .overflow(overflow), .overflow_clr(overflow_clr),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [NUM_CH-1:0] valid, input logic [31:0] data);
        in_valid = valid;
        in_data  = data;
    endtask

    task automatic expect_byte(input logic [1:0] ch, input logic [7:0] data);
        exp_q.push_back({ch, data});
    endtask

    // Judge the transfer presented to the coming rising edge, then move to the next falling edge.
    task automatic tick();
        logic [9:0] e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_output("out_data", 32'(out_data), 32'(e[7:0]));
                check_output("out_channel", 32'(out_channel), 32'(e[9:8]));
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_output("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        out_ready    = 1'b0;
        overflow_clr = '0;
        apply_stimulus('0, '0);
        exp_q.delete();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n      = 1'b0;
        out_ready    = 1'b0;
        overflow_clr = '0;
        apply_stimulus('0, '0);

        $display("[TB] reset state");
        do_reset();
        check_output("rst_valid", 32'(out_valid), 32'd0);
        check_output("rst_data", 32'(out_data), 32'd0);
        check_output("rst_channel", 32'(out_channel), 32'd0);
        check_output("rst_overflow", 32'(overflow), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);

        $display("[TB] single byte latency on ch2");
        out_ready = 1'b1;
        apply_stimulus(4'b0100, 32'h00A5_0000);
        expect_byte(2'd2, 8'hA5);
        tick();
        apply_stimulus('0, '0);
        check_output("t1_valid_t", 32'(out_valid), 32'd0);
        check_output("t1_busy_t", 32'(busy), 32'd1);
        tick();
        check_output("t1_valid_t1", 32'(out_valid), 32'd1);
        check_output("t1_data_t1", 32'(out_data), 32'hA5);
        check_output("t1_chan_t1", 32'(out_channel), 32'd2);
        tick();
        repeat (3) tick();
        check_output("t1_left", 32'(exp_q.size()), 32'd0);
        check_output("t1_busy_end", 32'(busy), 32'd0);

        $display("[TB] round-robin order with burst limit");
        do_reset();
        apply_stimulus(4'b1011, 32'h3100_1101);
        tick();
        apply_stimulus(4'b1001, 32'h3200_0002);
        tick();
        apply_stimulus(4'b0001, 32'h0000_0003);
        tick();
        apply_stimulus('0, '0);
        expect_byte(2'd0, 8'h01);
        expect_byte(2'd0, 8'h02);
        expect_byte(2'd1, 8'h11);
        expect_byte(2'd3, 8'h31);
        expect_byte(2'd3, 8'h32);
        expect_byte(2'd0, 8'h03);
        out_ready = 1'b1;
        drain(60);
        repeat (3) tick();
        check_output("t2_busy_end", 32'(busy), 32'd0);

        $display("[TB] overflow on ch1");
        do_reset();
        for (int b = 0; b < 5; b++) begin
            apply_stimulus(4'b0010, {16'h0, 8'(8'h41 + b), 8'h0});
            tick();
        end
        apply_stimulus('0, '0);
        check_output("t3_overflow_set", 32'(overflow), 32'h2);
        check_output("t3_hold_data", 32'(out_data), 32'h41);
        check_output("t3_hold_chan", 32'(out_channel), 32'd1);
        overflow_clr = 4'b0010;
        tick();
        overflow_clr = '0;
        check_output("t3_overflow_clr", 32'(overflow), 32'h0);
        for (int b = 0; b < 4; b++) expect_byte(2'd1, 8'(8'h41 + b));
        out_ready = 1'b1;
        drain(40);

        $display("[TB] backpressure hold on ch2");
        do_reset();
        apply_stimulus(4'b0100, 32'h0077_0000);
        tick();
        apply_stimulus(4'b0100, 32'h0078_0000);
        tick();
        apply_stimulus('0, '0);
        for (int w = 0; w < 5 && out_valid !== 1'b1; w++) tick();
        check_output("t4_valid", 32'(out_valid), 32'd1);
        for (int c = 0; c < 3; c++) begin
            check_output("t4_hold_valid", 32'(out_valid), 32'd1);
            check_output("t4_hold_data", 32'(out_data), 32'h77);
            check_output("t4_hold_chan", 32'(out_channel), 32'd2);
            tick();
        end
        expect_byte(2'd2, 8'h77);
        expect_byte(2'd2, 8'h78);
        out_ready = 1'b1;
        drain(40);

        $display("[TB] reset mid-burst");
        do_reset();
        for (int b = 0; b < 5; b++) begin
            apply_stimulus((b < 3) ? 4'b1001 : 4'b1000,
                           {8'(8'h31 + b), 16'h0, 8'(8'h01 + b)});
            tick();
        end
        apply_stimulus('0, '0);
        check_output("t5_overflow_pre", 32'(overflow), 32'h8);
        check_output("t5_chan_pre", 32'(out_channel), 32'd0);
        expect_byte(2'd0, 8'h01);
        out_ready = 1'b1;
        tick();
        check_output("t5_popped", 32'(exp_q.size()), 32'd0);
        do_reset();
        check_output("t5_valid", 32'(out_valid), 32'd0);
        check_output("t5_overflow", 32'(overflow), 32'd0);
        check_output("t5_busy", 32'(busy), 32'd0);
        out_ready = 1'b1;
        repeat (8) tick();
        check_output("t5_no_stale", 32'(out_valid), 32'd0);

`ifdef PCIE_WRAP0_BYTE_ARB_CH0_PRIO_EN
        $display("[TB] channel 0 priority");
        do_reset();
        for (int b = 0; b < 3; b++) begin
            apply_stimulus(4'b0010, {16'h0, 8'(8'h11 + b), 8'h0});
            tick();
        end
        apply_stimulus(4'b0101, 32'h0021_0001);
        tick();
        apply_stimulus(4'b0001, 32'h0000_0002);
        tick();
        apply_stimulus(4'b0001, 32'h0000_0003);
        tick();
        apply_stimulus('0, '0);
        check_output("t6_gnt_ch1", 32'(out_channel), 32'd1);
        expect_byte(2'd1, 8'h11);
        expect_byte(2'd1, 8'h12);
        expect_byte(2'd0, 8'h01);
        expect_byte(2'd0, 8'h02);
        expect_byte(2'd0, 8'h03);
        expect_byte(2'd2, 8'h21);
        expect_byte(2'd1, 8'h13);
        out_ready = 1'b1;
        drain(80);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
